uart_rx: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the existing uart_tx, at the same configurable baud rate.
- Synchronises the asynchronous rx pin, detects the start bit and checks it at mid-bit.
- Samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Presents each good byte with a one-cycle valid pulse; flags bad stop bits separately.
- Sits between the FPGA serial pin and the host-bridge logic.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants.
package uart_pkg;

    localparam int DEFAULT_CLOCKS_PER_BAUD = 868;
    localparam int DATA_BITS               = 8;
    localparam int STOP_BITS               = 1;

    typedef enum logic [2:0] {
        ST_BREAK = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= {WIDTH{RESET_VAL}};
            sync_reg <= {WIDTH{RESET_VAL}};
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid per good byte,
// one-cycle framing_error when the stop bit is low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int HALF  = CLOCKS_PER_BAUD / 2;
    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD) + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t        state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       sr_reg,     sr_next;
    logic [7:0]       data_reg,   data_next;
    logic             valid_reg,  valid_next;
    logic             ferr_reg,   ferr_next;
    logic             busy_reg,   busy_next;
    logic             sample;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign sample = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_BREAK;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            sr_reg      <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            sr_reg      <= sr_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        sr_next      = sr_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;

        case (state_reg)
            // Hold off after reset or a bad stop bit until the line is idle high,
            // otherwise a stuck-low line would be taken as a start bit.
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_next   = HALF_LOAD;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next     = BAUD_LOAD;
                        bit_idx_next = '0;
                        state_next   = ST_DATA;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_DATA: begin
                if (sample) begin
                    sr_next  = {rx_s, sr_reg[7:1]};
                    cnt_next = BAUD_LOAD;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            // Leaving at mid-stop-bit lets a start bit follow with no idle gap.
            ST_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        data_next  = sr_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = ST_BREAK;
            end
        endcase

        busy_next = (state_next == ST_START) ||
                    (state_next == ST_DATA)  ||
                    (state_next == ST_STOP);
    end

    assign data          = data_reg;
    assign valid         = valid_reg;
    assign framing_error = ferr_reg;
    assign busy          = busy_reg;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-clock/bit instance for timing and error
// cases, and a 32-clock/bit instance fed by a 33-clock/bit transmitter model.
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int CPB_LB = 32;
    localparam int CPB_TX = 33;
    // Raw fall to valid: 2 sync + HALF + 9 bits + 1 register stage.
    localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst, rx;
    logic [7:0] data;
    logic       valid, framing_error, busy;

    logic       rst_lb, rx_lb;
    logic [7:0] data_lb;
    logic       valid_lb, framing_error_lb, busy_lb;

    always #5 clk = ~clk;

    uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    uart_rx #(.CLOCKS_PER_BAUD(CPB_LB)) dut_lb (
        .clk           (clk),
        .rst           (rst_lb),
        .rx            (rx_lb),
        .data          (data_lb),
        .valid         (valid_lb),
        .framing_error (framing_error_lb),
        .busy          (busy_lb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor for the 16-clock instance.
    logic [7:0] rx_data_q[$];
    int         rx_cyc_q[$];
    bit         busy_hist[int];
    int         ferr_cnt    = 0;
    int         ferr_cyc    = 0;
    int         overlap_cnt = 0;

    always @(negedge clk) begin
        busy_hist[cyc] = busy;
        if (valid) begin
            rx_data_q.push_back(data);
            rx_cyc_q.push_back(cyc);
            $display("rx byte 0x%02h at cycle %0d", data, cyc);
        end
        if (framing_error) begin
            ferr_cnt++;
            ferr_cyc = cyc;
            $display("framing error at cycle %0d", cyc);
        end
        if (valid && framing_error) overlap_cnt++;
    end

    // Monitor for the loopback instance: bytes must arrive as 0,1,2,...
    int lb_count = 0;
    int lb_ferr  = 0;

    always @(negedge clk) begin
        if (valid_lb) begin
            $display("loopback byte 0x%02h at cycle %0d", data_lb, cyc);
            check("lb_data", {24'b0, data_lb}, lb_count);
            lb_count++;
        end
        if (framing_error_lb) lb_ferr++;
    end

    int fall = 0;
    int seen = 0;

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send16(input logic [7:0] b, input logic stop_v, input int stop_n);
        fall = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop_v, stop_n);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp_b);
        check({tag, "_count"}, rx_data_q.size(), seen + 1);
        if (rx_data_q.size() > seen) begin
            check({tag, "_data"}, {24'b0, rx_data_q[seen]}, {24'b0, exp_b});
            check({tag, "_latency"}, rx_cyc_q[seen] - fall, LAT);
        end
        seen = rx_data_q.size();
    endtask

    initial begin
        logic [7:0] b77;
        int         busy_lo;
        int         f0;
        int         ferr_before;

        rst = 1'b1; rx = 1'b1; rst_lb = 1'b1; rx_lb = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data",  {24'b0, data}, 32'h0);
        check("rst_valid", valid, 0);
        check("rst_ferr",  framing_error, 0);
        check("rst_busy",  busy, 0);
        rst = 1'b0; rst_lb = 1'b0;

        fork
            begin : main_seq
                repeat (10) @(negedge clk);

                // Single frame: latency, data, busy window.
                send16(8'hA5, 1'b1, CPB);
                expect_frame("a5", 8'hA5);
                check("a5_ferr", ferr_cnt, 0);
                check("a5_busy_t0", busy_hist[fall + 2], 0);
                busy_lo = 0;
                for (int c = fall + 3; c <= fall + LAT - 1; c++)
                    if (!busy_hist[c]) busy_lo++;
                check("a5_busy_frame", busy_lo, 0);
                check("a5_busy_end", busy_hist[fall + LAT], 0);

                // Back-to-back frames, no idle gap.
                f0 = cyc;
                send16(8'h00, 1'b1, CPB);
                send16(8'hFF, 1'b1, CPB);
                send16(8'h5A, 1'b1, CPB);
                check("b2b_count", rx_data_q.size(), seen + 3);
                if (rx_data_q.size() >= seen + 3) begin
                    check("b2b_d0", {24'b0, rx_data_q[seen]},     32'h00);
                    check("b2b_d1", {24'b0, rx_data_q[seen + 1]}, 32'hFF);
                    check("b2b_d2", {24'b0, rx_data_q[seen + 2]}, 32'h5A);
                    check("b2b_t0", rx_cyc_q[seen] - f0, LAT);
                    check("b2b_gap1", rx_cyc_q[seen + 1] - rx_cyc_q[seen], 10 * CPB);
                    check("b2b_gap2", rx_cyc_q[seen + 2] - rx_cyc_q[seen + 1], 10 * CPB);
                end
                seen = rx_data_q.size();

                // Short glitch is rejected at the mid-start sample.
                drive(1'b1, 5);
                fall = cyc;
                drive(1'b0, 3);
                drive(1'b1, 30);
                check("glitch_no_valid", rx_data_q.size(), seen);
                check("glitch_busy_hi", busy_hist[fall + 3], 1);
                check("glitch_busy_lo", busy_hist[fall + 12], 0);
                send16(8'h3C, 1'b1, CPB);
                expect_frame("3c", 8'h3C);

                drive(1'b1, 5);
                send16(8'h96, 1'b1, CPB);
                expect_frame("96", 8'h96);

                // Stop bit held low: framing error, then BREAK until line high.
                drive(1'b1, 5);
                ferr_before = ferr_cnt;
                send16(8'h3C, 1'b0, 40);
                check("fe_count", ferr_cnt, ferr_before + 1);
                check("fe_time", ferr_cyc - fall, LAT);
                check("fe_no_valid", rx_data_q.size(), seen);
                check("fe_data_hold", {24'b0, data}, 32'h96);
                check("fe_busy_break", busy_hist[fall + 170], 0);
                drive(1'b1, 20);
                check("fe_no_false_start", rx_data_q.size(), seen);
                send16(8'h81, 1'b1, CPB);
                expect_frame("81", 8'h81);

                // Reset in the middle of the data bits.
                drive(1'b1, 5);
                b77 = 8'h77;
                drive(1'b0, CPB);
                for (int i = 0; i < 4; i++) drive(b77[i], CPB);
                rst = 1'b1;
                rx  = 1'b1;
                repeat (2) @(negedge clk);
                check("mrst_data",  {24'b0, data}, 32'h0);
                check("mrst_valid", valid, 0);
                check("mrst_ferr",  framing_error, 0);
                check("mrst_busy",  busy, 0);
                rst = 1'b0;
                drive(1'b1, 8 * CPB);
                check("mrst_dropped", rx_data_q.size(), seen);
                send16(8'h12, 1'b1, CPB);
                expect_frame("12", 8'h12);

                drive(1'b1, 20);
                check("valid_ferr_overlap", overlap_cnt, 0);
                check("total_ferr", ferr_cnt, 1);
            end

            begin : loopback_seq
                logic [7:0] bb;
                repeat (10) @(negedge clk);
                for (int b = 0; b < 256; b++) begin
                    bb = b[7:0];
                    rx_lb = 1'b0;
                    repeat (CPB_TX) @(negedge clk);
                    for (int i = 0; i < 8; i++) begin
                        rx_lb = bb[i];
                        repeat (CPB_TX) @(negedge clk);
                    end
                    rx_lb = 1'b1;
                    repeat (CPB_TX) @(negedge clk);
                end
                repeat (200) @(negedge clk);
                check("lb_count", lb_count, 256);
                check("lb_ferr", lb_ferr, 0);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
